// File: rtl/ascon_inv_sigma_seq_if.sv
// Request/response bundle for the inverse Ascon sigma unit.
interface ascon_inv_sigma_seq_if;
  logic        req_valid;
  logic        req_ready;
  logic [63:0] req_rs1;
  logic [4:0]  req_imm;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [63:0] rsp_rd;
  logic        rsp_err;

  modport master (
    output req_valid, req_rs1, req_imm, rsp_ready,
    input  req_ready, rsp_valid, rsp_rd, rsp_err
  );

  modport slave (
    input  req_valid, req_rs1, req_imm, rsp_ready,
    output req_ready, rsp_valid, rsp_rd, rsp_err
  );
endinterface

// File: rtl/ascon_inv_sigma_seq.sv
// Iterative inverse Ascon linear layer: rd = sigma_i^-1(rs1) as six doubled-rotation sigma steps.
// Latency: 1 + 6/UNROLL cycles from accept to rsp_valid (1 cycle for an illegal row).
// Backpressure: result held in DONE until rsp_ready; no request accepted outside IDLE.
module ascon_inv_sigma_seq #(
  parameter int UNROLL = 1
) (
  input  logic                        g_clk,
  input  logic                        g_resetn,
  ascon_inv_sigma_seq_if.slave        bus
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  state_e      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [63:0] x_q, x_d;
  logic [5:0]  ra_q, ra_d;
  logic [5:0]  rb_q, rb_d;
  logic        err_q, err_d;
  logic        req_ready;

  // Shift by 64 yields zero, so amount 0 degenerates cleanly to identity.
  function automatic logic [63:0] ror64(input logic [63:0] v, input logic [5:0] s);
    return (v >> s) | (v << (7'd64 - {1'b0, s}));
  endfunction

  assign req_ready     = (state_q == IDLE) && g_resetn;
  assign bus.req_ready = req_ready;
  assign bus.rsp_valid = (state_q == DONE);
  assign bus.rsp_rd    = (state_q == DONE) ? x_q : '0;
  assign bus.rsp_err   = (state_q == DONE) && err_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    x_d     = x_q;
    ra_d    = ra_q;
    rb_d    = rb_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (bus.req_valid && req_ready) begin
          x_d   = bus.req_rs1;
          cnt_d = '0;
          err_d = 1'b0;
          case (bus.req_imm)
            5'd0: begin ra_d = 6'd19; rb_d = 6'd28; end
            5'd1: begin ra_d = 6'd61; rb_d = 6'd39; end
            5'd2: begin ra_d = 6'd1;  rb_d = 6'd6;  end
            5'd3: begin ra_d = 6'd10; rb_d = 6'd17; end
            5'd4: begin ra_d = 6'd7;  rb_d = 6'd41; end
            default: begin
              ra_d  = '0;
              rb_d  = '0;
              x_d   = '0;
              err_d = 1'b1;
            end
          endcase
          state_d = err_d ? DONE : BUSY;
        end
      end
      BUSY: begin
        // Each step squares the previous factor: amounts double mod 64.
        for (int k = 0; k < UNROLL; k++) begin
          x_d  = x_d ^ ror64(x_d, ra_d) ^ ror64(x_d, rb_d);
          ra_d = {ra_d[4:0], 1'b0};
          rb_d = {rb_d[4:0], 1'b0};
        end
        cnt_d = cnt_q + 3'(UNROLL);
        if (cnt_d >= 3'd6) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (bus.rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      x_q     <= '0;
      ra_q    <= '0;
      rb_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      x_q     <= x_d;
      ra_q    <= ra_d;
      rb_q    <= rb_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: doc/ascon_inv_sigma_seq.md
Name: ascon_inv_sigma_seq

Overview:
- Iterative unit computing the inverse of the Ascon linear diffusion layer: rd = Σ_i⁻¹(rs1) for row i = 0..4.
- Σ_i(x) = x ^ ror(x,a_i) ^ ror(x,b_i); L = I+R^a+R^b satisfies L^64 = I, so Σ⁻¹ = L^63 = Π_{k=0..5} (I + R^(a·2^k mod 64) + R^(b·2^k mod 64)).
- Applies those six sigma-like steps over several cycles; used for Ascon decryption-side ISE experiments and as a checker for the forward sigma ISE.
- Sits beside the forward sigma unit in the rv64 ISE datapath behind a valid/ready request/response interface.

Parameters:
- UNROLL, 1, steps applied per cycle; legal 1, 2, 3, 6; compute latency = 6/UNROLL cycles.

Ports:
- g_clk  in  1  clock, all state rising-edge.
- g_resetn  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept request.
- req_rs1  in  64  operand x.
- req_imm  in  5  row select i (0..4).
- rsp_valid  out  1  result present.
- rsp_ready  in  1  consumer accepts result.
- rsp_rd  out  64  result Σ_i⁻¹(x), or 0 on error.
- rsp_err  out  1  illegal req_imm (>4).

Behaviour:
- Clocking/reset: one clock g_clk; reset g_resetn asynchronous, active-low. While low: state=IDLE, step counter=0, data register=0, rotation registers=0, req_ready=0 then 1 in IDLE after release, rsp_valid=0, rsp_rd=0, rsp_err=0.
- Row table (a,b), 6-bit amounts: 0:(19,28) 1:(61,39) 2:(1,6) 3:(10,17) 4:(7,41).
- States: IDLE, BUSY, DONE.
- IDLE: req_ready=1. On req_valid&req_ready: latch x, ra=a, rb=b, cnt=0. Legal imm -> BUSY. Illegal imm -> DONE with rd=0, err=1 (latency 1).
- BUSY: req_ready=0. Each cycle apply UNROLL steps; each step: x <= x ^ ror(x,ra) ^ ror(x,rb), then ra <= (ra<<1) mod 64, rb <= (rb<<1) mod 64, cnt += 1. After cnt reaches 6 -> DONE.
- Rotation is right-rotate over full 64 bits; amount 0 is identity (for a=1 at k=6 amount would wrap to 0; never used since only k=0..5 applied).
- DONE: rsp_valid=1, rsp_rd/rsp_err stable until rsp_valid&rsp_ready; then -> IDLE next cycle. req_ready=0 in DONE (no same-cycle accept).
- Latency legal imm, UNROLL=1: request accepted cycle T -> rsp_valid high from T+7 (6 BUSY cycles).
- rsp_ready held low: result held indefinitely, no new request accepted.
- req_valid deasserted/changed while not ready: ignored; operands sampled only at handshake.
- rsp_rd and rsp_err are registered outputs; no combinational path from req_* to rsp_*.
- Async reset at any point (including mid-BUSY or DONE) discards the operation; no response issued.
- rsp_rd = 0 whenever rsp_valid = 0.

Test Plan:
- imm=2, rs1=0x8400000000000001 -> rsp_rd=0x0000000000000001, err=0, rsp_valid 7 cycles after accept (UNROLL=1).
- imm=0, rs1=0x0000201000000001 -> rsp_rd=0x0000000000000001; rs1=0 -> 0; rs1=0xFFFFFFFFFFFFFFFF -> 0xFFFFFFFFFFFFFFFF.
- Round trip all imm 0..4, 1000 random x: forward Σ_i model then this unit -> rsp_rd == x; repeat for UNROLL=2,3,6 with latency 3,2,1 compute cycles.
- imm=7, any rs1 -> rsp_valid next cycle after accept, rsp_rd=0, rsp_err=1.
- rsp_ready low 20 cycles in DONE -> rsp_rd stable, req_ready=0, new req_valid not accepted; accept after release.
- g_resetn pulsed low mid-BUSY (cycle 3) -> rsp_valid=0 immediately, IDLE after release, next request (imm=2, 0x8400000000000001) yields 0x1 correctly.
